// File: rtl/cpa_slice_sequencer.sv
// Digit-serial adder sequencer driving one external carry-propagate adder slice.
// Optional CPA_SEQ_SUB_EN adds a sub_i port for two's-complement subtraction.
module cpa_slice_sequencer #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef CPA_SEQ_SUB_EN
    input  logic             sub_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             c_out_o,
    output logic [SLICE-1:0] slice_a_o,
    output logic [SLICE-1:0] slice_b_o,
    output logic             slice_cin_o,
    input  logic [SLICE-1:0] slice_s_i,
    input  logic             slice_cout_i
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || SLICE > WIDTH) begin : g_bad_cfg
        $error("cpa_slice_sequencer: WIDTH must be a non-zero multiple of SLICE");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] b_d;
    logic             cin_d;
    logic [WIDTH-1:0] res_d;
    logic [KW-1:0]    k_d;

    // Subtraction is a + ~b + 1; c_out then reads as "no borrow".
    always_comb begin
`ifdef CPA_SEQ_SUB_EN
        b_d   = sub_i ? ~b_i : b_i;
        cin_d = sub_i ? 1'b1 : c_in_i;
`else
        b_d   = b_i;
        cin_d = c_in_i;
`endif
    end

    always_comb begin
        res_d = res_q;
        res_d[int'(k_q) * SLICE +: SLICE] = slice_s_i;
        k_d   = k_q + KW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            res_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        a_q     <= a_i;
                        b_q     <= b_d;
                        cin_q   <= cin_d;
                        carry_q <= 1'b0;
                        res_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    res_q   <= res_d;
                    carry_q <= slice_cout_i;
                    if (k_q == K_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                        s_q     <= res_d;
                        c_out_q <= slice_cout_i;
                    end else begin
                        k_q <= k_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Slice drive decodes registers only, so the external adder sees no input-port paths.
    assign slice_a_o   = busy_q ? a_q[int'(k_q) * SLICE +: SLICE] : '0;
    assign slice_b_o   = busy_q ? b_q[int'(k_q) * SLICE +: SLICE] : '0;
    assign slice_cin_o = busy_q ? ((k_q == '0) ? cin_q : carry_q) : 1'b0;

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign s_o     = s_q;
    assign c_out_o = c_out_q;

endmodule
